// File: rtl/maze_pkg.sv
// Shared constants for the maze renderer: colours, wall bit positions, clear FSM states.
package maze_pkg;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] GREEN = 12'h0F0;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] BLUE  = 12'h00F;
  localparam logic [11:0] TRAIL = 12'h8CF;

  // Bit positions inside a cell's {N,E,S,W} wall nibble
  localparam int unsigned WALL_N = 3;
  localparam int unsigned WALL_E = 2;
  localparam int unsigned WALL_S = 1;
  localparam int unsigned WALL_W = 0;

  typedef enum logic [0:0] {IDLE, CLEAR} state_e;

  // Linear cell index, row-major
  function automatic int unsigned cell_addr(input logic [5:0] row, input logic [5:0] col,
                                            input int unsigned cols);
    return ({26'd0, row} * cols) + {26'd0, col};
  endfunction

endpackage

// File: rtl/maze_cell_ram.sv
// Wall map storage: one write port, one registered read port, no reset on contents.
module maze_cell_ram #(
  parameter int unsigned Depth = 225,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [3:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [3:0]       rdata_o
);

  logic [3:0] mem_q [Depth];

  // Write and registered read; a read of the address being written returns the old value
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/maze_renderer.sv
// Maze-to-pixel renderer. Two register stages: S1 pixel/cell counters + map read,
// S2 colour decision into rgb. A clear FSM fills the map with all walls.
// Optional build macro MAZE_TRAIL_EN adds a visited-cell bitmap drawn in TRAIL colour.
module maze_renderer
  import maze_pkg::*;
#(
  parameter int unsigned ROWS    = 15,
  parameter int unsigned COLS    = 15,
  parameter int unsigned CELL_PX = 20,
  parameter int unsigned WALL_PX = 5,
  parameter int unsigned X0      = 314,
  parameter int unsigned Y0      = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        wr_en,
  input  logic [5:0]  wr_row,
  input  logic [5:0]  wr_col,
  input  logic [3:0]  wr_walls,
  input  logic        clr_start,
  output logic        busy,
  input  logic [5:0]  start_row,
  input  logic [5:0]  start_col,
  input  logic [5:0]  finish_row,
  input  logic [5:0]  finish_col,
  input  logic [5:0]  player_row,
  input  logic [5:0]  player_col,
  output logic [11:0] rgb
);

  localparam int unsigned Depth = ROWS * COLS;
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PxW   = $clog2(CELL_PX);

  localparam logic [10:0]      XBeg     = 11'(X0);
  localparam logic [10:0]      XEnd     = 11'(X0 + COLS * CELL_PX);
  localparam logic [10:0]      YBeg     = 11'(Y0);
  localparam logic [10:0]      YEnd     = 11'(Y0 + ROWS * CELL_PX);
  localparam logic [PxW-1:0]   PxLast   = PxW'(CELL_PX - 1);
  localparam logic [PxW-1:0]   WallLo   = PxW'(WALL_PX);
  localparam logic [PxW-1:0]   WallHi   = PxW'(CELL_PX - WALL_PX);
  localparam logic [6:0]       RowsL    = 7'(ROWS);
  localparam logic [6:0]       ColsL    = 7'(COLS);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

  logic [10:0] h_ext, v_ext;
  assign h_ext = {1'b0, hCount};
  assign v_ext = {1'b0, vCount};

  // S1 state
  logic [PxW-1:0] px_q, px_d, py_q, py_d;
  logic [5:0]     cell_col_q, cell_col_d, cell_row_q, cell_row_d;
  logic           in_maze_q, in_maze_d, bright_q;
  logic [5:0]     start_row_q, start_col_q, finish_row_q, finish_col_q;
  logic [5:0]     player_row_q, player_col_q;

  // Clear FSM state
  state_e         state_q;
  logic           busy_q;
  logic [AddrW-1:0] clr_addr_q;

  // Map ports
  logic             rd_valid;
  logic [AddrW-1:0] rd_addr;
  logic [3:0]       rd_walls;
  logic             ram_we;
  logic [AddrW-1:0] ram_waddr;
  logic [3:0]       ram_wdata;

  logic [11:0] rgb_q, rgb_d;

  // S1 next state: counters resync on the maze's left column and above its top row
  always_comb begin
    px_d       = px_q;
    cell_col_d = cell_col_q;
    if (h_ext == XBeg) begin
      px_d       = '0;
      cell_col_d = '0;
    end else if (px_q == PxLast) begin
      px_d       = '0;
      cell_col_d = cell_col_q + 6'd1;
    end else begin
      px_d = px_q + PxW'(1);
    end

    py_d       = py_q;
    cell_row_d = cell_row_q;
    if (v_ext < YBeg) begin
      py_d       = '0;
      cell_row_d = '0;
    end else if (h_ext == XEnd) begin
      if (py_q == PxLast) begin
        py_d       = '0;
        cell_row_d = cell_row_q + 6'd1;
      end else begin
        py_d = py_q + PxW'(1);
      end
    end

    in_maze_d = (h_ext >= XBeg) && (h_ext < XEnd) && (v_ext >= YBeg) && (v_ext < YEnd);
  end

  // Map read is addressed from the S1 next state so its data lines up with the S1 registers
  assign rd_valid = ({1'b0, cell_row_d} < RowsL) && ({1'b0, cell_col_d} < ColsL);
  assign rd_addr  = rd_valid ? AddrW'(cell_addr(cell_row_d, cell_col_d, COLS)) : '0;

  // S1 registers: counters, maze window, video qualifier and marker coordinates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      px_q         <= '0;
      py_q         <= '0;
      cell_col_q   <= '0;
      cell_row_q   <= '0;
      in_maze_q    <= 1'b0;
      bright_q     <= 1'b0;
      start_row_q  <= '0;
      start_col_q  <= '0;
      finish_row_q <= '0;
      finish_col_q <= '0;
      player_row_q <= '0;
      player_col_q <= '0;
    end else begin
      px_q         <= px_d;
      py_q         <= py_d;
      cell_col_q   <= cell_col_d;
      cell_row_q   <= cell_row_d;
      in_maze_q    <= in_maze_d;
      bright_q     <= bright;
      start_row_q  <= start_row;
      start_col_q  <= start_col;
      finish_row_q <= finish_row;
      finish_col_q <= finish_col;
      player_row_q <= player_row;
      player_col_q <= player_col;
    end
  end

  // Clear FSM: one map word per cycle; busy mirrors the CLEAR state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q    <= CLEAR;
            busy_q     <= 1'b1;
            clr_addr_q <= '0;
          end
        end
        CLEAR: begin
          if (clr_addr_q == LastAddr) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + AddrW'(1);
          end
        end
      endcase
    end
  end

  // Map write mux: clear owns the port; user writes only in IDLE, in range, without clr_start
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr_q;
    ram_wdata = 4'hF;
    if (state_q == CLEAR) begin
      ram_we = 1'b1;
    end else if (wr_en && !clr_start && ({1'b0, wr_row} < RowsL) && ({1'b0, wr_col} < ColsL)) begin
      ram_we    = 1'b1;
      ram_waddr = AddrW'(cell_addr(wr_row, wr_col, COLS));
      ram_wdata = wr_walls;
    end
  end

  maze_cell_ram #(
    .Depth (Depth),
    .AddrW (AddrW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_walls)
  );

`ifdef MAZE_TRAIL_EN
  logic [Depth-1:0] visited_q;
  logic             trail_hit_q;
  logic             pl_valid, pl_moved;
  logic [AddrW-1:0] pl_addr;

  assign pl_valid = ({1'b0, player_row} < RowsL) && ({1'b0, player_col} < ColsL);
  assign pl_moved = (player_row != player_row_q) || (player_col != player_col_q);
  assign pl_addr  = AddrW'(cell_addr(player_row, player_col, COLS));

  // Visited bitmap: mark the cell the player moves into; the clear sweep wipes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      visited_q <= '0;
    end else begin
      if (pl_moved && pl_valid) visited_q[pl_addr] <= 1'b1;
      if (state_q == CLEAR) visited_q[clr_addr_q] <= 1'b0;
    end
  end

  // Visited lookup, timed like the map read
  always_ff @(posedge clk) begin
    if (!rst_n) trail_hit_q <= 1'b0;
    else        trail_hit_q <= rd_valid & visited_q[rd_addr];
  end
`endif

  // S2 colour decision in priority order
  always_comb begin
    logic is_wall;
    is_wall = (rd_walls[WALL_N] && (py_q < WallLo)) || (rd_walls[WALL_S] && (py_q >= WallHi)) ||
              (rd_walls[WALL_W] && (px_q < WallLo)) || (rd_walls[WALL_E] && (px_q >= WallHi));
    rgb_d = WHITE;
    if (!bright_q) begin
      rgb_d = BLACK;
    end else if (!in_maze_q) begin
      rgb_d = WHITE;
    end else if (is_wall) begin
      rgb_d = BLACK;
    end else if ((cell_row_q == player_row_q) && (cell_col_q == player_col_q)) begin
      rgb_d = BLUE;
`ifdef MAZE_TRAIL_EN
    end else if (trail_hit_q) begin
      rgb_d = TRAIL;
`endif
    end else if ((cell_row_q == finish_row_q) && (cell_col_q == finish_col_q)) begin
      rgb_d = RED;
    end else if ((cell_row_q == start_row_q) && (cell_col_q == start_col_q)) begin
      rgb_d = GREEN;
    end else begin
      rgb_d = WHITE;
    end
  end

  // S2 register
  always_ff @(posedge clk) begin
    if (!rst_n) rgb_q <= BLACK;
    else        rgb_q <= rgb_d;
  end

  assign rgb  = rgb_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_maze_renderer.sv
// Directed bench for maze_renderer: default-size instance plus a 4x4 instance for a full sweep.
module tb_maze_renderer;

  localparam int X0  = 314;
  localparam int Y0  = 125;
  localparam int XE  = X0 + 15 * 20;
  localparam int X0S = 6;
  localparam int Y0S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, bright, wr_en, clr_start, busy;
  logic [9:0]  hc, vc;
  logic [5:0]  wr_row, wr_col, st_r, st_c, fi_r, fi_c, pl_r, pl_c;
  logic [3:0]  wr_walls;
  logic [11:0] rgb;

  logic        s_wr_en, s_busy;
  logic [9:0]  s_hc, s_vc;
  logic [5:0]  s_wr_row, s_wr_col;
  logic [3:0]  s_wr_walls;
  logic [11:0] s_rgb;
  logic [3:0]  smap [16];

  int checks = 0;
  int errors = 0;

  maze_renderer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bright     (bright),
    .hCount     (hc),
    .vCount     (vc),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_walls   (wr_walls),
    .clr_start  (clr_start),
    .busy       (busy),
    .start_row  (st_r),
    .start_col  (st_c),
    .finish_row (fi_r),
    .finish_col (fi_c),
    .player_row (pl_r),
    .player_col (pl_c),
    .rgb        (rgb)
  );

  maze_renderer #(
    .ROWS    (4),
    .COLS    (4),
    .CELL_PX (8),
    .WALL_PX (2),
    .X0      (X0S),
    .Y0      (Y0S)
  ) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .bright     (1'b1),
    .hCount     (s_hc),
    .vCount     (s_vc),
    .wr_en      (s_wr_en),
    .wr_row     (s_wr_row),
    .wr_col     (s_wr_col),
    .wr_walls   (s_wr_walls),
    .clr_start  (1'b0),
    .busy       (s_busy),
    .start_row  (6'd3),
    .start_col  (6'd3),
    .finish_row (6'd0),
    .finish_col (6'd3),
    .player_row (6'd2),
    .player_col (6'd1),
    .rgb        (s_rgb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v);
    hc = 10'(h);
    vc = 10'(v);
    step();
  endtask

  // Scan to maze-relative pixel (dx,dy) the way the timing generator would, then one more
  // cycle so rgb holds that pixel's colour
  task automatic goto_px(input int dx, input int dy);
    drive(0, Y0 - 1);
    for (int l = 0; l < dy; l++) drive(XE, Y0 + l);
    for (int i = 0; i <= dx; i++) drive(X0 + i, Y0 + dy);
    drive(0, Y0 + dy);
  endtask

  task automatic write_cell(input int r, input int c, input logic [3:0] w);
    wr_en    = 1'b1;
    wr_row   = 6'(r);
    wr_col   = 6'(c);
    wr_walls = w;
    step();
    wr_en    = 1'b0;
  endtask

  // Reference colour for the 4x4 instance (8 px cells, 2 px walls, fixed markers)
  function automatic logic [11:0] ref_px(input int h, input int v);
    int row, col, px, py;
    logic [3:0] w;
    if (h < X0S || h >= X0S + 32 || v < Y0S || v >= Y0S + 32) return 12'hFFF;
    col = (h - X0S) / 8;
    row = (v - Y0S) / 8;
    px  = (h - X0S) % 8;
    py  = (v - Y0S) % 8;
    w   = smap[row * 4 + col];
    if ((w[3] && py < 2) || (w[1] && py >= 6) || (w[0] && px < 2) || (w[2] && px >= 6))
      return 12'h000;
    if (row == 2 && col == 1) return 12'h00F;
    if (row == 0 && col == 3) return 12'hF00;
    if (row == 3 && col == 3) return 12'h0F0;
    return 12'hFFF;
  endfunction

  initial begin
    int n;
    logic [11:0] prev_exp;
    bit have_prev;

    rst_n = 1'b0; bright = 1'b1; hc = '0; vc = '0;
    wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_walls = '0; clr_start = 1'b0;
    st_r = 6'd63; st_c = 6'd63; fi_r = 6'd63; fi_c = 6'd63; pl_r = 6'd63; pl_c = 6'd63;
    s_wr_en = 1'b0; s_wr_row = '0; s_wr_col = '0; s_wr_walls = '0; s_hc = '0; s_vc = '0;
    step();
    step();
    check("rst_rgb", 32'(rgb), 32'h000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_small_rgb", 32'(s_rgb), 32'h000);
    rst_n = 1'b1;

    // Full sweep of the 4x4 instance against the reference, result one step behind the input
    for (int i = 0; i < 16; i++) begin
      smap[i]    = 4'($urandom_range(0, 15));
      s_wr_en    = 1'b1;
      s_wr_row   = 6'(i / 4);
      s_wr_col   = 6'(i % 4);
      s_wr_walls = smap[i];
      step();
    end
    s_wr_en   = 1'b0;
    have_prev = 1'b0;
    prev_exp  = '0;
    for (int v = 0; v < Y0S + 34; v++) begin
      for (int h = 0; h < X0S + 34; h++) begin
        s_hc = 10'(h);
        s_vc = 10'(v);
        step();
        if (have_prev) check($sformatf("sweep_%0d_%0d", h, v), 32'(s_rgb), 32'(prev_exp));
        prev_exp  = ref_px(h, v);
        have_prev = 1'b1;
      end
    end

    // North and west walls of cell (0,0)
    write_cell(0, 0, 4'h9);
    goto_px(10, 2);
    check("t1_north_wall", 32'(rgb), 32'h000);
    goto_px(10, 10);
    check("t1_floor", 32'(rgb), 32'hFFF);

    // Empty map, start then finish on the same cell
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++) write_cell(r, c, 4'h0);
    st_r = 6'd14; st_c = 6'd0;
    goto_px(10, 290);
    check("t2_start", 32'(rgb), 32'h0F0);
    fi_r = 6'd14; fi_c = 6'd0;
    goto_px(10, 290);
    check("t2_finish_over_start", 32'(rgb), 32'hF00);

    // Clear: length, ignored writes and ignored restart while busy
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    wr_en = 1'b1; wr_row = 6'd0; wr_col = 6'd0; wr_walls = 4'h0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      clr_start = (n == 100);
      step();
    end
    wr_en = 1'b0;
    clr_start = 1'b0;
    check("t3_busy_cycles", 32'(n), 32'd225);
    check("t3_busy_low", 32'(busy), 32'd0);
    goto_px(10, 2);
    check("t3_north", 32'(rgb), 32'h000);
    goto_px(2, 10);
    check("t3_west_write_dropped", 32'(rgb), 32'h000);
    goto_px(17, 10);
    check("t3_east", 32'(rgb), 32'h000);
    goto_px(10, 17);
    check("t3_south", 32'(rgb), 32'h000);
    goto_px(10, 10);
    check("t3_centre", 32'(rgb), 32'hFFF);

    // Out-of-range writes and markers, grid edges, blanking
    write_cell(15, 0, 4'h0);
    write_cell(0, 15, 4'h0);
    goto_px(10, 22);
    check("t4_oob_write", 32'(rgb), 32'h000);
    goto_px(299, 299);
    check("t4_last_px_wall", 32'(rgb), 32'h000);
    goto_px(300, 10);
    check("t4_right_of_maze", 32'(rgb), 32'hFFF);
    goto_px(10, 300);
    check("t4_below_maze", 32'(rgb), 32'hFFF);
    drive(5, 5);
    drive(0, 5);
    check("t4_outside", 32'(rgb), 32'hFFF);
    pl_r = 6'd20; pl_c = 6'd3;
    goto_px(70, 90);
    check("t4_player_oob", 32'(rgb), 32'hFFF);
    pl_r = 6'd14; pl_c = 6'd0;
    goto_px(10, 290);
    check("t4_player_over_finish", 32'(rgb), 32'h00F);
    bright = 1'b0;
    goto_px(10, 10);
    check("t4_blank", 32'(rgb), 32'h000);
    bright = 1'b1;

`ifdef MAZE_TRAIL_EN
    // Trail left behind the player, then wiped by a clear
    pl_r = 6'd0; pl_c = 6'd0; step();
    pl_r = 6'd0; pl_c = 6'd1; step();
    pl_r = 6'd1; pl_c = 6'd1; step();
    goto_px(10, 10);
    check("t6_trail_00", 32'(rgb), 32'h8CF);
    goto_px(30, 10);
    check("t6_trail_01", 32'(rgb), 32'h8CF);
    goto_px(30, 30);
    check("t6_player_11", 32'(rgb), 32'h00F);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
    check("t6_clear_cycles", 32'(n), 32'd225);
    goto_px(10, 10);
    check("t6_trail_wiped", 32'(rgb), 32'hFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
